// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared alu opcodes, latency constant and tag type
package alu_arb_pkg;

  localparam int ALU_LAT = 2;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b1000;
  localparam logic [3:0] OP_OR  = 4'b1001;
  localparam logic [3:0] OP_XOR = 4'b1010;
  localparam logic [3:0] OP_NOT = 4'b1011;
  localparam logic [3:0] OP_SHR = 4'b1100;
  localparam logic [3:0] OP_SHL = 4'b1101;
  localparam logic [3:0] OP_ROR = 4'b1110;
  localparam logic [3:0] OP_ROL = 4'b1111;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - two-stage registered 8-bit alu: operands captured, result registered
module alu
  import alu_arb_pkg::*;
(
  input  logic       ck,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic [3:0] CTR,
  output logic [7:0] Y
);

  logic [7:0] a_q, b_q, res;
  logic [3:0] ctr_q;

  always_ff @(posedge ck) begin
    a_q   <= A;
    b_q   <= B;
    ctr_q <= CTR;
  end

  // Unary ops ignore B; shifts and rotates move by one bit; undefined opcodes give zero.
  always_comb begin
    res = 8'h00;
    case (ctr_q)
      OP_ADD: res = a_q + b_q;
      OP_SUB: res = a_q - b_q;
      OP_AND: res = a_q & b_q;
      OP_OR:  res = a_q | b_q;
      OP_XOR: res = a_q ^ b_q;
      OP_NOT: res = ~a_q;
      OP_SHR: res = {1'b0, a_q[7:1]};
      OP_SHL: res = {a_q[6:0], 1'b0};
      OP_ROR: res = {a_q[0], a_q[7:1]};
      OP_ROL: res = {a_q[6:0], a_q[7]};
      default: res = 8'h00;
    endcase
  end

  always_ff @(posedge ck) begin
    Y <= res;
  end

endmodule

// File: rtl/rsp_fifo.sv
// rtl/rsp_fifo.sv - result buffer of {id, data} entries with occupancy count
module rsp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [8:0]               wdata,
  input  logic                     pop,
  output logic [8:0]               rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [8:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;

  assign rdata = mem[rd_ptr];

  always_ff @(posedge ck) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The issue credit must make this unreachable.
  a_no_overflow: assert property (@(posedge ck) disable iff (!rst_n)
    !(push && !pop && count == CW'(DEPTH)));

endmodule

// File: rtl/alu_arb.sv
// rtl/alu_arb.sv - two-lane round-robin front end sharing one alu, credit-limited result FIFO
module alu_arb
  import alu_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ALU_LAT    = alu_arb_pkg::ALU_LAT
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_ctr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        rsp_id,
  output logic        busy
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [CW-1:0] fifo_count;
  logic [CW:0]   credit_used;
  logic [1:0]    inflight;
  logic          last_grant;
  logic [1:0]    grant;
  logic          can_issue, xfer, xfer_id, push, pop;
  logic [7:0]    alu_a, alu_b, alu_y;
  logic [3:0]    alu_ctr;
  logic [8:0]    fifo_rdata;
  tag_t          tag_q [ALU_LAT];

  assign credit_used = (CW+1)'(fifo_count) + (CW+1)'(inflight);
  assign can_issue   = credit_used < (CW+1)'(FIFO_DEPTH);

  // On a tie the lane that did not win the previous issue goes next.
  always_comb begin
    grant = 2'b00;
    case (req_valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign req_ready = (rst_n && can_issue) ? grant : 2'b00;
  assign xfer      = |(req_valid & req_ready);
  assign xfer_id   = req_ready[1];

  assign alu_a   = xfer ? req_a[{xfer_id, 3'b000} +: 8] : 8'h00;
  assign alu_b   = xfer ? req_b[{xfer_id, 3'b000} +: 8] : 8'h00;
  assign alu_ctr = xfer ? req_ctr[{xfer_id, 2'b00} +: 4] : 4'b0000;

  alu u_alu (
    .ck  (ck),
    .A   (alu_a),
    .B   (alu_b),
    .CTR (alu_ctr),
    .Y   (alu_y)
  );

  assign push = tag_q[ALU_LAT-1].valid;
  assign pop  = rsp_valid & rsp_ready;

  always_ff @(posedge ck) begin
    if (!rst_n) begin
      for (int i = 0; i < ALU_LAT; i++) tag_q[i] <= '0;
      inflight   <= 2'd0;
      last_grant <= 1'b1;
    end else begin
      tag_q[0] <= '{valid: xfer, id: xfer_id};
      for (int i = 1; i < ALU_LAT; i++) tag_q[i] <= tag_q[i-1];
      if (xfer) last_grant <= xfer_id;
      case ({xfer, push})
        2'b10:   inflight <= inflight + 2'd1;
        2'b01:   inflight <= inflight - 2'd1;
        default: inflight <= inflight;
      endcase
    end
  end

  rsp_fifo #(.DEPTH(FIFO_DEPTH)) u_rsp_fifo (
    .ck    (ck),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({tag_q[ALU_LAT-1].id, alu_y}),
    .pop   (pop),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign rsp_valid = rst_n && (fifo_count != '0);
  assign rsp_data  = fifo_rdata[7:0];
  assign rsp_id    = fifo_rdata[8];
  assign busy      = rst_n && ((inflight != 2'd0) || (fifo_count != '0));

endmodule

// File: tb/tb_alu_arb.sv
// tb/tb_alu_arb.sv - directed self-checking bench for alu_arb
module tb_alu_arb;
  import alu_arb_pkg::*;

  logic        ck = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_a, req_b;
  logic [7:0]  req_ctr;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [7:0]  rsp_data;

  int total = 0;
  int bad   = 0;
  logic [8:0] got_q [$];

  always #5 ck = ~ck;

  alu_arb #(.FIFO_DEPTH(4), .ALU_LAT(2)) dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ctr   (req_ctr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
  );

  always @(negedge ck) begin
    if (rst_n && rsp_valid && rsp_ready) got_q.push_back({rsp_id, rsp_data});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge ck);
    #1;
  endtask

  task automatic set_lane(input int lane, input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    req_a[lane*8 +: 8]   = a;
    req_b[lane*8 +: 8]   = b;
    req_ctr[lane*4 +: 4] = op;
  endtask

  task automatic idle;
    req_valid = 2'b00;
    req_a     = '0;
    req_b     = '0;
    req_ctr   = '0;
  endtask

  task automatic drain;
    for (int i = 0; i < 60 && busy; i++) tick;
    check("drain", 32'(busy), 32'd0);
  endtask

  task automatic expect_pop(input string tag, input logic id, input logic [7:0] data);
    logic [8:0] e;
    if (got_q.size() == 0) begin
      check({tag, "_missing"}, 32'd0, 32'd1);
    end else begin
      e = got_q.pop_front();
      check(tag, 32'(e), 32'({id, data}));
    end
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
  } vec_t;

  vec_t vecs [6];
  int   k;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{OP_ROR,  8'h81, 8'h00, 8'hC0};
    vecs[1] = '{OP_SUB,  8'h02, 8'h05, 8'hFD};
    vecs[2] = '{4'b0010, 8'h5A, 8'hA5, 8'h00};
    vecs[3] = '{OP_XOR,  8'hF0, 8'h3C, 8'hCC};
    vecs[4] = '{OP_SHL,  8'h81, 8'h00, 8'h02};
    vecs[5] = '{OP_NOT,  8'h0F, 8'h00, 8'hF0};

    // reset state with both lanes requesting
    idle;
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    tick; tick;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle;
    tick;
    check("post_rst_busy", 32'(busy), 32'd0);

    // both lanes valid for six cycles: alternating grants from lane 0
    for (int c = 0; c < 6; c++) begin
      set_lane(0, 8'h10, 8'(c), OP_ADD);
      set_lane(1, 8'h20, 8'(c), OP_ADD);
      req_valid = 2'b11;
      #1;
      check("rr_grant", 32'(req_ready), (c % 2) ? 32'd2 : 32'd1);
      tick;
    end
    idle;
    drain;
    for (int c = 0; c < 6; c++)
      expect_pop("rr_result", 1'((c % 2) != 0), ((c % 2) ? 8'h20 : 8'h10) + 8'(c));
    check("rr_count", 32'(got_q.size()), 32'd0);

    // single ADD latency
    set_lane(0, 8'h05, 8'h03, OP_ADD);
    req_valid = 2'b01;
    #1;
    check("lat_ready", 32'(req_ready), 32'd1);
    tick;
    idle;
    check("lat_t1_valid", 32'(rsp_valid), 32'd0);
    check("lat_t1_busy", 32'(busy), 32'd1);
    tick;
    check("lat_t2_valid", 32'(rsp_valid), 32'd0);
    tick;
    check("lat_t3_valid", 32'(rsp_valid), 32'd1);
    check("lat_t3_data", 32'(rsp_data), 32'h08);
    check("lat_t3_id", 32'(rsp_id), 32'd0);
    tick;
    drain;
    got_q.delete();

    // lane 1 opcode vectors
    foreach (vecs[i]) begin
      set_lane(1, vecs[i].a, vecs[i].b, vecs[i].op);
      req_valid = 2'b10;
      #1;
      check("vec_ready", 32'(req_ready), 32'd2);
      tick;
      idle;
    end
    drain;
    foreach (vecs[i]) expect_pop("vec_result", 1'b1, vecs[i].y);

    // backpressure: credit stops issue at four, then resumes in order
    got_q.delete();
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      set_lane(0, 8'(k), 8'h00, OP_ADD);
      req_valid = 2'b01;
      #1;
      if (req_ready[0]) k++;
      tick;
    end
    check("bp_transfers", 32'(k), 32'd4);
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_head_valid", 32'(rsp_valid), 32'd1);
    check("bp_head_data", 32'({rsp_id, rsp_data}), 32'h000);
    tick;
    check("bp_head_hold", 32'({rsp_id, rsp_data}), 32'h000);
    rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      set_lane(0, 8'(k), 8'h00, OP_ADD);
      req_valid = 2'b01;
      #1;
      if (req_ready[0]) k++;
      tick;
    end
    idle;
    drain;
    check("bp_resumed", 32'(k > 4), 32'd1);
    check("bp_result_count", 32'(got_q.size()), 32'(k));
    for (int i = 0; i < k; i++) expect_pop("bp_order", 1'b0, 8'(i));

    // reset after two transfers discards everything
    got_q.delete();
    for (int c = 0; c < 2; c++) begin
      set_lane(0, 8'h11, 8'h22, OP_ADD);
      req_valid = 2'b01;
      #1;
      check("rstmid_ready", 32'(req_ready), 32'd1);
      tick;
    end
    rst_n = 1'b0;
    #1;
    check("rstmid_ready_low", 32'(req_ready), 32'd0);
    tick;
    rst_n = 1'b1;
    idle;
    for (int c = 0; c < 6; c++) begin
      check("rstmid_valid", 32'(rsp_valid), 32'd0);
      check("rstmid_busy", 32'(busy), 32'd0);
      tick;
    end
    check("rstmid_no_results", 32'(got_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
